// File: rtl/jam_cost_responder.sv
// rtl/jam_cost_responder.sv - 8x8 worker/job cost table: streamed load, same-cycle lookup, load checksum and wrap counter
module jam_cost_responder #(
    parameter int COST_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LdStart,
    input  logic              LdValid,
    input  logic [COST_W-1:0] LdData,
    output logic              LdReady,
    output logic              TableReady,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    output logic [12:0]       Checksum,
    output logic [CNT_W-1:0]  PermCount
);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

    state_t            state;
    logic [5:0]        addr;
    logic [2:0]        prev_w;
    logic [COST_W-1:0] cost_tbl [0:63];
    logic              accept;
    logic              wrap;
    logic [CNT_W-1:0]  cnt_max;

    assign accept  = LdValid && LdReady;
    assign wrap    = (prev_w == 3'd7) && (W == 3'd0);
    assign cnt_max = '1;

    // The engine samples Cost the cycle after it registers W/J, so no pipeline stage here
    assign Cost = TableReady ? cost_tbl[{W, J}] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr       <= 6'd0;
            prev_w     <= 3'd0;
            Checksum   <= 13'd0;
            PermCount  <= '0;
            LdReady    <= 1'b0;
            TableReady <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                cost_tbl[i] <= '0;
            end
        end else begin
            prev_w <= W;
            if (LdStart) begin
                state      <= LOAD;
                addr       <= 6'd0;
                Checksum   <= 13'd0;
                PermCount  <= '0;
                LdReady    <= 1'b1;
                TableReady <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (accept) begin
                            cost_tbl[addr] <= LdData;
                            addr           <= addr + 6'd1;
                            Checksum       <= Checksum + 13'(LdData);
                            if (addr == 6'd63) begin
                                state      <= SERVE;
                                LdReady    <= 1'b0;
                                TableReady <= 1'b1;
                            end
                        end
                    end
                    SERVE: begin
                        if (wrap && (PermCount != cnt_max)) begin
                            PermCount <= PermCount + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jam_cost_responder.sv
// tb/tb_jam_cost_responder.sv - scoreboard bench for jam_cost_responder
module tb_jam_cost_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LdStart;
    logic        LdValid;
    logic [6:0]  LdData;
    logic        LdReady;
    logic        TableReady;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic [12:0] Checksum;
    logic [15:0] PermCount;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] exp_q [$];
    logic [6:0] model_tbl [0:63];
    int         exp_cnt;
    logic [2:0] model_prev_w;

    jam_cost_responder #(.COST_W(7), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .LdStart(LdStart), .LdValid(LdValid), .LdData(LdData),
        .LdReady(LdReady), .TableReady(TableReady), .W(W), .J(J), .Cost(Cost),
        .Checksum(Checksum), .PermCount(PermCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start;
        LdStart = 1'b1;
        step;
        LdStart = 1'b0;
    endtask

    task automatic do_load(input int kind, input int stall_after, output int cycles);
        int beat   = 0;
        int stalls = 0;
        cycles = 0;
        while (TableReady !== 1'b1 && cycles < 300) begin
            if (beat == stall_after && stalls < 3) begin
                LdValid = 1'b0;
                stalls++;
            end else begin
                LdValid = 1'b1;
                LdData  = (kind == 0) ? 7'(beat) : 7'd1;
                if (beat < 64) model_tbl[beat] = LdData;
                beat++;
            end
            step;
            cycles++;
        end
        LdValid = 1'b0;
    endtask

    task automatic lookup(input logic [2:0] w, input logic [2:0] j, input logic [6:0] expv);
        logic [6:0] e;
        W = w;
        J = j;
        exp_q.push_back(expv);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (Cost !== e) begin
            miscompares++;
            $display("FAIL cost W=%0d J=%0d: got %0d expected %0d", w, j, Cost, e);
        end
    endtask

    task automatic check_table;
        for (int idx = 0; idx < 64; idx++) begin
            lookup(idx[5:3], idx[2:0], model_tbl[idx]);
        end
    endtask

    task automatic drive_w(input logic [2:0] v);
        W = v;
        if (model_prev_w == 3'd7 && v == 3'd0 && exp_cnt < 65535) exp_cnt++;
        model_prev_w = v;
        step;
        vectors++;
        if (PermCount !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL perm_count_track: got %0d expected %0d", PermCount, exp_cnt);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; LdStart = 1'b0; LdValid = 1'b0; LdData = 7'd0;
        W = 3'd3; J = 3'd5;
        for (int i = 0; i < 64; i++) model_tbl[i] = 7'd0;
        step;
        step;
        vectors += 5;
        if (Cost !== 7'd0)        begin miscompares++; $display("FAIL reset_cost: got %0d expected 0", Cost); end
        if (LdReady !== 1'b0)     begin miscompares++; $display("FAIL reset_ldready: got %b expected 0", LdReady); end
        if (TableReady !== 1'b0)  begin miscompares++; $display("FAIL reset_tableready: got %b expected 0", TableReady); end
        if (Checksum !== 13'd0)   begin miscompares++; $display("FAIL reset_checksum: got %0d expected 0", Checksum); end
        if (PermCount !== 16'd0)  begin miscompares++; $display("FAIL reset_permcount: got %0d expected 0", PermCount); end
        RST = 1'b0;
        step;
    endtask

    task automatic test_full_load;
        int cyc;
        pulse_start;
        vectors += 3;
        if (LdReady !== 1'b1)    begin miscompares++; $display("FAIL load_ldready: got %b expected 1", LdReady); end
        if (TableReady !== 1'b0) begin miscompares++; $display("FAIL load_tableready: got %b expected 0", TableReady); end
        if (Cost !== 7'd0)       begin miscompares++; $display("FAIL load_cost_masked: got %0d expected 0", Cost); end
        do_load(0, -1, cyc);
        vectors += 3;
        if (cyc != 64)             begin miscompares++; $display("FAIL full_load_latency: got %0d cycles expected 64", cyc); end
        if (LdReady !== 1'b0)      begin miscompares++; $display("FAIL full_load_ldready_fall: got %b expected 0", LdReady); end
        if (Checksum !== 13'd2016) begin miscompares++; $display("FAIL full_load_checksum: got %0d expected 2016", Checksum); end
        lookup(3'd6, 3'd2, 7'd50);
        lookup(3'd7, 3'd7, 7'd63);
        check_table;
    endtask

    task automatic test_stalled_load;
        int cyc;
        pulse_start;
        do_load(0, 10, cyc);
        vectors += 2;
        if (cyc != 67)             begin miscompares++; $display("FAIL stalled_latency: got %0d cycles expected 67", cyc); end
        if (Checksum !== 13'd2016) begin miscompares++; $display("FAIL stalled_checksum: got %0d expected 2016", Checksum); end
        check_table;
    endtask

    task automatic test_restart;
        int cyc;
        pulse_start;
        for (int b = 0; b < 20; b++) begin
            LdValid = 1'b1;
            LdData  = 7'd127;
            model_tbl[b] = 7'd127;
            step;
        end
        LdStart = 1'b1;
        step;
        LdStart = 1'b0;
        LdValid = 1'b0;
        vectors += 3;
        if (LdReady !== 1'b1)    begin miscompares++; $display("FAIL restart_ldready: got %b expected 1", LdReady); end
        if (TableReady !== 1'b0) begin miscompares++; $display("FAIL restart_tableready: got %b expected 0", TableReady); end
        if (Checksum !== 13'd0)  begin miscompares++; $display("FAIL restart_checksum_clear: got %0d expected 0", Checksum); end
        do_load(1, -1, cyc);
        vectors += 2;
        if (cyc != 64)           begin miscompares++; $display("FAIL restart_latency: got %0d cycles expected 64", cyc); end
        if (Checksum !== 13'd64) begin miscompares++; $display("FAIL restart_checksum: got %0d expected 64", Checksum); end
        check_table;
    endtask

    task automatic test_eval_count;
        int cyc;
        W = 3'd3;
        pulse_start;
        do_load(1, -1, cyc);
        exp_cnt      = 0;
        model_prev_w = 3'd3;
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 8; w++) drive_w(3'(w));
            drive_w(3'd7);
        end
        drive_w(3'd0);
        drive_w(3'd1);
        vectors++;
        if (PermCount !== 16'd5) begin miscompares++; $display("FAIL eval_count: got %0d expected 5", PermCount); end
    endtask

    task automatic test_saturation;
        drive_w(3'd3);
        force dut.PermCount = 16'd65533;
        step;
        release dut.PermCount;
        step;
        exp_cnt      = 65533;
        model_prev_w = 3'd3;
        vectors++;
        if (PermCount !== 16'd65533) begin miscompares++; $display("FAIL sat_preload: got %0d expected 65533", PermCount); end
        for (int k = 0; k < 4; k++) begin
            drive_w(3'd7);
            drive_w(3'd0);
        end
        vectors++;
        if (PermCount !== 16'd65535) begin miscompares++; $display("FAIL sat_hold: got %0d expected 65535", PermCount); end
        pulse_start;
        vectors += 3;
        if (PermCount !== 16'd0) begin miscompares++; $display("FAIL reload_permcount: got %0d expected 0", PermCount); end
        if (TableReady !== 1'b0) begin miscompares++; $display("FAIL reload_tableready: got %b expected 0", TableReady); end
        if (LdReady !== 1'b1)    begin miscompares++; $display("FAIL reload_ldready: got %b expected 1", LdReady); end
    endtask

    initial begin
        test_reset;
        test_full_load;
        test_stalled_load;
        test_restart;
        test_eval_count;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
